// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-seven-segment table for the scan driver.
package seg7_pkg;

    localparam int SEG_W  = 8;
    localparam int DIGITS = 8;
    localparam int NIB_W  = 4;

    // Segment masks, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_A  = 8'h01;
    localparam logic [SEG_W-1:0] SEG_B  = 8'h02;
    localparam logic [SEG_W-1:0] SEG_C  = 8'h04;
    localparam logic [SEG_W-1:0] SEG_D  = 8'h08;
    localparam logic [SEG_W-1:0] SEG_E  = 8'h10;
    localparam logic [SEG_W-1:0] SEG_F  = 8'h20;
    localparam logic [SEG_W-1:0] SEG_G  = 8'h40;
    localparam logic [SEG_W-1:0] SEG_DP = 8'h80;

    // Hex digit to active-high segment pattern; the decimal point is never lit.
    function automatic logic [SEG_W-1:0] hex7(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] s;
        case (nib)
            4'h0: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            4'h1: s = SEG_B | SEG_C;
            4'h2: s = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
            4'h3: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
            4'h4: s = SEG_B | SEG_C | SEG_F | SEG_G;
            4'h5: s = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
            4'h6: s = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h7: s = SEG_A | SEG_B | SEG_C;
            4'h8: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h9: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
            4'hA: s = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
            4'hB: s = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'hC: s = SEG_A | SEG_D | SEG_E | SEG_F;
            4'hD: s = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
            4'hE: s = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
            default: s = SEG_A | SEG_E | SEG_F | SEG_G;
        endcase
        return s & ~SEG_DP;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble decoder feeding the segment output register.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [SEG_W-1:0] seg
);

    // Pure table lookup, no state
    assign seg = hex7(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with per-frame snapshot,
// leading-zero blanking and a dark guard interval at the start of each slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int GUARD_CYCLES = 16,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DIGITS*NIB_W-1:0] seg_data,
    input  logic                    disp_en,
    output logic [DIGITS-1:0]       seg_an,
    output logic [SEG_W-1:0]        seg_out,
    output logic                    frame_tick
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // A slot must leave at least one lit cycle after the guard interval
    generate
        if (DIV <= GUARD_CYCLES) begin : g_bad_div
            $error("seg7_scan_driver: CLK_HZ/SCAN_HZ must exceed GUARD_CYCLES");
        end
    endgenerate

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [DIGITS*NIB_W-1:0] snap;
    logic [DIGITS-1:0]       blank_vec;
    logic [NIB_W-1:0]        nib_p0;
    logic [SEG_W-1:0]        seg_dec_p0;
    logic                    show_p0;

    // Digit k is a leading zero when it and every more significant nibble are zero
    always_comb begin
        blank_vec = '0;
        for (int k = 0; k < DIGITS; k++) begin
            blank_vec[k] = (LZ_BLANK != 0) && (k != 0) &&
                           ((snap >> (NIB_W * k)) == '0);
        end
    end

    assign nib_p0  = snap[NIB_W*idx +: NIB_W];
    assign show_p0 = disp_en && (cnt >= GUARD_C) && !blank_vec[idx];

    hex_to_seg7 u_dec (
        .nib (nib_p0),
        .seg (seg_dec_p0)
    );

    // Slot counter, digit index and frame snapshot taken on the last cycle of digit 7
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (cnt == CNT_LAST) && (idx == IDX_LAST);
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 1'b1;
                if (idx == IDX_LAST) begin
                    snap <= seg_data;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered digit enable and segment pattern, one cycle behind cnt/idx
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_an  <= '0;
            seg_out <= '0;
        end else begin
            seg_an  <= show_p0 ? (DIGITS'(1) << idx) : '0;
            seg_out <= show_p0 ? seg_dec_p0 : '0;
        end
    end

endmodule
